// File: rtl/lock_pattern_datapath_pkg.sv
// Shared sizing defaults for the combination-lock datapath and the
// selector used by the entry display mux.
package lock_pkg;

    localparam int DEF_DIGIT_W    = 4;
    localparam int DEF_NUM_DIGITS = 4;
    localparam int DEF_MAX_FAIL   = 3;

    // Length counters must hold NUM_DIGITS, fail counter must hold MAX_FAIL.
    localparam int DEF_LEN_W  = $clog2(DEF_NUM_DIGITS + 1);
    localparam int DEF_FAIL_W = $clog2(DEF_MAX_FAIL + 1);

    // Which entry register the display is currently following.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PAT  = 2'd1,
        SRC_TEST = 2'd2
    } disp_src_e;

endpackage

// File: rtl/lock_pattern_datapath_digit_shift_reg.sv
// Keypad entry register: shifts accepted digits in at the LSB end and
// counts them; a digit arriving when the register is full is dropped and
// flagged for one cycle on full_drop.
module digit_shift_reg #(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4,
    parameter int LEN_W      = 3
) (
    input  logic                          clka,
    input  logic                          restart,
    input  logic                          clear,
    input  logic                          enable,
    input  logic                          digit_valid,
    input  logic [DIGIT_W-1:0]            digit_in,
    output logic [NUM_DIGITS*DIGIT_W-1:0] value,
    output logic [LEN_W-1:0]              len,
    output logic                          full_drop
);

    localparam int VAL_W = NUM_DIGITS * DIGIT_W;

    logic [VAL_W-1:0] value_q, value_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [VAL_W-1:0] base_value;
    logic [LEN_W-1:0] base_len;

    // Next entry contents: a clear in the same cycle as a digit still lets
    // that digit land in the freshly emptied register.
    always_comb begin
        base_value = clear ? '0 : value_q;
        base_len   = clear ? '0 : len_q;
        value_d    = base_value;
        len_d      = base_len;
        full_drop  = 1'b0;
        if (enable && digit_valid) begin
            if (base_len < LEN_W'(NUM_DIGITS)) begin
                value_d = (base_value << DIGIT_W) | VAL_W'(digit_in);
                len_d   = base_len + LEN_W'(1);
            end else begin
                full_drop = 1'b1;
            end
        end
    end

    // Entry state register, updated on the controller's falling edge.
    always_ff @(negedge clka) begin
        if (restart) begin
            value_q <= '0;
            len_q   <= '0;
        end else begin
            value_q <= value_d;
            len_q   <= len_d;
        end
    end

    assign value = value_q;
    assign len   = len_q;

endmodule

// File: rtl/lock_pattern_datapath.sv
// Combination-lock datapath: captures pattern and test digit entries,
// commits and compares them for the controller, counts consecutive failed
// attempts into a lockout, and mirrors the entry in progress to a display.
module lock_pattern_datapath
    import lock_pkg::*;
#(
    parameter int DIGIT_W    = DEF_DIGIT_W,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int MAX_FAIL   = DEF_MAX_FAIL,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int FAIL_W     = DEF_FAIL_W
) (
    input  logic                          clka,
    input  logic                          restart,
    input  logic [DIGIT_W-1:0]            digit_in,
    input  logic                          digit_valid,
    input  logic                          save_pat_temp_sig,
    input  logic                          save_pat_sig,
    input  logic                          save_test_temp_sig,
    input  logic                          save_test_sig,
    input  logic                          match,
    input  logic                          error,
    output logic                          same_sig,
    output logic [LEN_W-1:0]              pat_len,
    output logic [LEN_W-1:0]              test_len,
    output logic [FAIL_W-1:0]             fail_count,
    output logic                          lockout,
    output logic                          overflow,
    output logic [NUM_DIGITS*DIGIT_W-1:0] display_digits
);

    localparam int VAL_W = NUM_DIGITS * DIGIT_W;

    // Edge-detect history.
    logic pat_temp_prev_q, pat_temp_prev_d;
    logic test_temp_prev_q, test_temp_prev_d;
    logic match_prev_q, match_prev_d;
    logic error_prev_q, error_prev_d;

    // Committed values and status.
    logic [VAL_W-1:0]  pat_reg_q, pat_reg_d;
    logic [VAL_W-1:0]  test_reg_q, test_reg_d;
    logic [LEN_W-1:0]  pat_len_q, pat_len_d;
    logic [LEN_W-1:0]  test_len_q, test_len_d;
    logic              same_q, same_d;
    logic [FAIL_W-1:0] fail_q, fail_d;
    logic              lockout_q, lockout_d;
    logic              overflow_q, overflow_d;
    logic [VAL_W-1:0]  display_q, display_d;

    // Strobe qualification.
    logic pat_rise, test_rise, match_rise, error_rise;
    logic pat_side_busy;
    logic pat_clear, pat_enable;
    logic test_clear, test_enable, test_commit;
    disp_src_e disp_src;

    // Entry register interfaces.
    logic [VAL_W-1:0] pat_temp, test_temp;
    logic [LEN_W-1:0] pat_tlen, test_tlen;
    logic             pat_drop, test_drop;

    // Rise detection and arbitration: any pattern-side strobe silences the
    // test side for that cycle, and a pattern commit silences pattern entry.
    always_comb begin
        pat_rise      = save_pat_temp_sig & ~pat_temp_prev_q;
        test_rise     = save_test_temp_sig & ~test_temp_prev_q;
        match_rise    = match & ~match_prev_q;
        error_rise    = error & ~error_prev_q;
        pat_side_busy = save_pat_sig | save_pat_temp_sig;
        pat_clear     = pat_rise & ~save_pat_sig;
        pat_enable    = save_pat_temp_sig & ~save_pat_sig;
        test_clear    = test_rise & ~pat_side_busy;
        test_enable   = save_test_temp_sig & ~pat_side_busy & ~lockout_q;
        test_commit   = save_test_sig & ~pat_side_busy;
    end

    digit_shift_reg #(
        .DIGIT_W    (DIGIT_W),
        .NUM_DIGITS (NUM_DIGITS),
        .LEN_W      (LEN_W)
    ) u_pat_entry (
        .clka        (clka),
        .restart     (restart),
        .clear       (pat_clear),
        .enable      (pat_enable),
        .digit_valid (digit_valid),
        .digit_in    (digit_in),
        .value       (pat_temp),
        .len         (pat_tlen),
        .full_drop   (pat_drop)
    );

    digit_shift_reg #(
        .DIGIT_W    (DIGIT_W),
        .NUM_DIGITS (NUM_DIGITS),
        .LEN_W      (LEN_W)
    ) u_test_entry (
        .clka        (clka),
        .restart     (restart),
        .clear       (test_clear),
        .enable      (test_enable),
        .digit_valid (digit_valid),
        .digit_in    (digit_in),
        .value       (test_temp),
        .len         (test_tlen),
        .full_drop   (test_drop)
    );

    // Commit, compare, fail tracking, overflow and display next-state.
    always_comb begin
        pat_temp_prev_d  = save_pat_temp_sig;
        test_temp_prev_d = save_test_temp_sig;
        match_prev_d     = match;
        error_prev_d     = error;

        pat_reg_d  = pat_reg_q;
        pat_len_d  = pat_len_q;
        test_reg_d = test_reg_q;
        test_len_d = test_len_q;
        fail_d     = fail_q;
        lockout_d  = lockout_q;
        overflow_d = overflow_q;

        if (test_commit) begin
            test_reg_d = test_temp;
            test_len_d = test_tlen;
        end

        // Match resets the streak; an error rise alone extends it.
        if (match_rise) begin
            fail_d    = '0;
            lockout_d = 1'b0;
        end else if (error_rise) begin
            if (fail_q != FAIL_W'(MAX_FAIL)) begin
                fail_d = fail_q + FAIL_W'(1);
            end
            lockout_d = (fail_d == FAIL_W'(MAX_FAIL));
        end

        // A new pattern commit starts the user over with a clean record.
        if (save_pat_sig) begin
            pat_reg_d = pat_temp;
            pat_len_d = pat_tlen;
            fail_d    = '0;
            lockout_d = 1'b0;
        end

        // Overflow belongs to the entry in progress: a new entry clears it.
        if (pat_clear || test_clear) begin
            overflow_d = 1'b0;
        end
        if (pat_drop || test_drop) begin
            overflow_d = 1'b1;
        end

        // Compares committed registers, so same_sig lags a commit by one edge.
        same_d = (pat_reg_q == test_reg_q) && (pat_len_q == test_len_q)
                 && (pat_len_q != '0);

        if (save_pat_temp_sig) begin
            disp_src = SRC_PAT;
        end else if (save_test_temp_sig) begin
            disp_src = SRC_TEST;
        end else begin
            disp_src = SRC_NONE;
        end

        case (disp_src)
            SRC_PAT:  display_d = pat_temp;
            SRC_TEST: display_d = test_temp;
            default:  display_d = '0;
        endcase
    end

    // All state updates on the falling edge; restart overrides everything.
    always_ff @(negedge clka) begin
        if (restart) begin
            pat_temp_prev_q  <= 1'b0;
            test_temp_prev_q <= 1'b0;
            match_prev_q     <= 1'b0;
            error_prev_q     <= 1'b0;
            pat_reg_q        <= '0;
            pat_len_q        <= '0;
            test_reg_q       <= '0;
            test_len_q       <= '0;
            same_q           <= 1'b0;
            fail_q           <= '0;
            lockout_q        <= 1'b0;
            overflow_q       <= 1'b0;
            display_q        <= '0;
        end else begin
            pat_temp_prev_q  <= pat_temp_prev_d;
            test_temp_prev_q <= test_temp_prev_d;
            match_prev_q     <= match_prev_d;
            error_prev_q     <= error_prev_d;
            pat_reg_q        <= pat_reg_d;
            pat_len_q        <= pat_len_d;
            test_reg_q       <= test_reg_d;
            test_len_q       <= test_len_d;
            same_q           <= same_d;
            fail_q           <= fail_d;
            lockout_q        <= lockout_d;
            overflow_q       <= overflow_d;
            display_q        <= display_d;
        end
    end

    assign same_sig       = same_q;
    assign pat_len        = pat_len_q;
    assign test_len       = test_len_q;
    assign fail_count     = fail_q;
    assign lockout        = lockout_q;
    assign overflow       = overflow_q;
    assign display_digits = display_q;

endmodule

// File: tb/tb_lock_pattern_datapath.sv
// Bench for lock_pattern_datapath: table of pattern/test entry pairs plus
// hand-written sequences for reset, latency, lockout, priority and overflow.
module tb_lock_pattern_datapath;

    logic        clka = 1'b0;
    logic        restart;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic        save_pat_temp_sig, save_pat_sig;
    logic        save_test_temp_sig, save_test_sig;
    logic        match, error;
    logic        same_sig;
    logic [2:0]  pat_len, test_len;
    logic [1:0]  fail_count;
    logic        lockout, overflow;
    logic [15:0] display_digits;

    lock_pattern_datapath dut (
        .clka               (clka),
        .restart            (restart),
        .digit_in           (digit_in),
        .digit_valid        (digit_valid),
        .save_pat_temp_sig  (save_pat_temp_sig),
        .save_pat_sig       (save_pat_sig),
        .save_test_temp_sig (save_test_temp_sig),
        .save_test_sig      (save_test_sig),
        .match              (match),
        .error              (error),
        .same_sig           (same_sig),
        .pat_len            (pat_len),
        .test_len           (test_len),
        .fail_count         (fail_count),
        .lockout            (lockout),
        .overflow           (overflow),
        .display_digits     (display_digits)
    );

    always #5 clka = ~clka;

    typedef enum int {O_SAME, O_PLEN, O_TLEN, O_FAIL, O_LOCK, O_OVF, O_DISP} osel_e;

    typedef struct {
        string       name;
        osel_e       sel;
        logic [31:0] exp;
    } exp_t;

    // Digits packed first-entered at [19:16]; up to five per entry.
    typedef struct {
        int          np;
        logic [19:0] pd;
        int          nt;
        logic [19:0] td;
        logic [2:0]  e_plen;
        logic [2:0]  e_tlen;
        logic        e_same;
        logic        e_ovf;
        logic [15:0] e_disp;
    } vec_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] read_out(osel_e sel);
        case (sel)
            O_SAME:  return 32'(same_sig);
            O_PLEN:  return 32'(pat_len);
            O_TLEN:  return 32'(test_len);
            O_FAIL:  return 32'(fail_count);
            O_LOCK:  return 32'(lockout);
            O_OVF:   return 32'(overflow);
            default: return 32'(display_digits);
        endcase
    endfunction

    // Inputs change at posedge; the DUT updates at negedge; this returns at
    // the following posedge with outputs settled.
    task automatic tick();
        @(negedge clka);
        @(posedge clka);
    endtask

    task automatic expect_out(string name, osel_e sel, logic [31:0] exp);
        sb_q.push_back('{name, sel, exp});
    endtask

    task automatic step_check();
        tick();
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e   = sb_q.pop_front();
            act = read_out(e.sel);
            n_vec++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%0h, want 0x%0h", e.name, act, e.exp);
            end
        end
    endtask

    task automatic idle_inputs();
        digit_in           = '0;
        digit_valid        = 1'b0;
        save_pat_temp_sig  = 1'b0;
        save_pat_sig       = 1'b0;
        save_test_temp_sig = 1'b0;
        save_test_sig      = 1'b0;
        match              = 1'b0;
        error              = 1'b0;
    endtask

    task automatic do_reset(int n);
        idle_inputs();
        restart = 1'b1;
        repeat (n) tick();
        restart = 1'b0;
    endtask

    // Raises the selected temp strobe and keys in n digits, first digit in
    // the rise cycle; the strobe is left high.
    task automatic enter(input bit is_pat, input logic [19:0] d, input int n);
        if (is_pat) save_pat_temp_sig = 1'b1;
        else        save_test_temp_sig = 1'b1;
        if (n == 0) begin
            tick();
        end
        for (int i = 0; i < n; i++) begin
            digit_in    = 4'(d >> (16 - 4 * i));
            digit_valid = 1'b1;
            tick();
        end
        digit_valid = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{4, 20'h12340, 4, 20'h12340, 3'd4, 3'd4, 1'b1, 1'b0, 16'h1234};
        vecs[1] = '{3, 20'h12300, 4, 20'h12300, 3'd3, 3'd4, 1'b0, 1'b0, 16'h0123};
        vecs[2] = '{0, 20'h00000, 0, 20'h00000, 3'd0, 3'd0, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{5, 20'h98765, 4, 20'h98760, 3'd4, 3'd4, 1'b1, 1'b1, 16'h9876};
        vecs[4] = '{1, 20'h50000, 1, 20'h60000, 3'd1, 3'd1, 1'b0, 1'b0, 16'h0005};
        vecs[5] = '{4, 20'h12340, 4, 20'h43210, 3'd4, 3'd4, 1'b0, 1'b0, 16'h1234};
        vecs[6] = '{2, 20'h12000, 5, 20'h34512, 3'd2, 3'd4, 1'b0, 1'b0, 16'h0012};

        idle_inputs();
        restart = 1'b1;
        @(posedge clka);

        // Reset state.
        expect_out("rst_same", O_SAME, 0);
        expect_out("rst_plen", O_PLEN, 0);
        expect_out("rst_tlen", O_TLEN, 0);
        expect_out("rst_fail", O_FAIL, 0);
        expect_out("rst_lock", O_LOCK, 0);
        expect_out("rst_ovf",  O_OVF,  0);
        expect_out("rst_disp", O_DISP, 0);
        step_check();
        restart = 1'b0;

        // Table: enter pattern, commit, enter test, commit, compare.
        for (int v = 0; v < 7; v++) begin
            do_reset(2);
            enter(1'b1, vecs[v].pd, vecs[v].np);
            expect_out($sformatf("v%0d_disp", v), O_DISP, 32'(vecs[v].e_disp));
            expect_out($sformatf("v%0d_ovf", v),  O_OVF,  32'(vecs[v].e_ovf));
            step_check();
            save_pat_temp_sig = 1'b0;
            save_pat_sig      = 1'b1;
            expect_out($sformatf("v%0d_plen", v), O_PLEN, 32'(vecs[v].e_plen));
            step_check();
            save_pat_sig = 1'b0;
            enter(1'b0, vecs[v].td, vecs[v].nt);
            tick();
            save_test_temp_sig = 1'b0;
            save_test_sig      = 1'b1;
            tick();
            save_test_sig = 1'b0;
            expect_out($sformatf("v%0d_tlen", v), O_TLEN, 32'(vecs[v].e_tlen));
            expect_out($sformatf("v%0d_same", v), O_SAME, 32'(vecs[v].e_same));
            step_check();
        end

        // Restart in the middle of a pattern entry discards it.
        do_reset(1);
        enter(1'b1, 20'h12000, 2);
        restart     = 1'b1;
        digit_in    = 4'h5;
        digit_valid = 1'b1;
        tick();
        expect_out("mid_rst_disp", O_DISP, 0);
        expect_out("mid_rst_ovf",  O_OVF,  0);
        expect_out("mid_rst_same", O_SAME, 0);
        expect_out("mid_rst_fail", O_FAIL, 0);
        step_check();
        restart     = 1'b0;
        digit_valid = 1'b0;
        tick();
        save_pat_temp_sig = 1'b0;
        tick();
        save_pat_sig = 1'b1;
        expect_out("mid_rst_plen", O_PLEN, 0);
        step_check();
        save_pat_sig = 1'b0;

        // same_sig latency of two edges after the test commit, then held.
        do_reset(2);
        enter(1'b1, 20'h12340, 4);
        tick();
        save_pat_temp_sig = 1'b0;
        save_pat_sig      = 1'b1;
        tick();
        save_pat_sig = 1'b0;
        enter(1'b0, 20'h12340, 4);
        tick();
        save_test_temp_sig = 1'b0;
        save_test_sig      = 1'b1;
        expect_out("lat_edge1", O_SAME, 0);
        step_check();
        save_test_sig = 1'b0;
        expect_out("lat_edge2", O_SAME, 1);
        step_check();
        for (int i = 0; i < 3; i++) begin
            expect_out("same_hold", O_SAME, 1);
            step_check();
        end
        error = 1'b1;
        expect_out("err_once", O_FAIL, 1);
        step_check();
        error = 1'b0;
        match = 1'b1;
        expect_out("match_clr", O_FAIL, 0);
        step_check();
        match = 1'b0;
        error = 1'b1;
        expect_out("err_again", O_FAIL, 1);
        step_check();
        error = 1'b0;
        tick();
        error = 1'b1;
        match = 1'b1;
        expect_out("match_wins", O_FAIL, 0);
        step_check();
        error = 1'b0;
        match = 1'b0;
        tick();

        // Three held errors lock out; further rises saturate.
        do_reset(2);
        for (int k = 1; k <= 4; k++) begin
            error = 1'b1;
            expect_out($sformatf("fail_rise%0d", k), O_FAIL, (k > 3) ? 3 : k);
            expect_out($sformatf("lock_rise%0d", k), O_LOCK, (k >= 3) ? 1 : 0);
            step_check();
            repeat (8) tick();
            expect_out($sformatf("fail_held%0d", k), O_FAIL, (k > 3) ? 3 : k);
            step_check();
            error = 1'b0;
            tick();
        end
        enter(1'b0, 20'h12345, 5);
        tick();
        save_test_temp_sig = 1'b0;
        save_test_sig      = 1'b1;
        expect_out("locked_tlen", O_TLEN, 0);
        expect_out("locked_ovf",  O_OVF,  0);
        step_check();
        save_test_sig = 1'b0;
        save_pat_sig  = 1'b1;
        expect_out("unlock_fail", O_FAIL, 0);
        expect_out("unlock_lock", O_LOCK, 0);
        step_check();
        save_pat_sig = 1'b0;

        // Both temp strobes with one digit: only the pattern side takes it.
        do_reset(2);
        save_pat_temp_sig  = 1'b1;
        save_test_temp_sig = 1'b1;
        digit_in           = 4'h7;
        digit_valid        = 1'b1;
        tick();
        digit_valid = 1'b0;
        expect_out("prio_disp", O_DISP, 32'h7);
        step_check();
        save_pat_temp_sig  = 1'b0;
        save_test_temp_sig = 1'b0;
        save_pat_sig       = 1'b1;
        expect_out("prio_plen", O_PLEN, 1);
        step_check();
        save_pat_sig  = 1'b0;
        save_test_sig = 1'b1;
        expect_out("prio_tlen", O_TLEN, 0);
        step_check();
        save_test_sig = 1'b0;

        // Overflow is sticky until a new entry begins.
        do_reset(2);
        enter(1'b1, 20'h98765, 5);
        expect_out("ovf_set", O_OVF, 1);
        step_check();
        save_pat_temp_sig = 1'b0;
        expect_out("ovf_sticky", O_OVF, 1);
        step_check();
        save_pat_temp_sig = 1'b1;
        expect_out("ovf_clear", O_OVF, 0);
        step_check();
        save_pat_temp_sig = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
